// File: rtl/nand_logic_pkg.sv
// Shared types and constants for the NAND-built logic unit and its self-test.
package nand_logic_pkg;

  typedef enum logic [2:0] {
    OP_NOT_A = 3'd0,
    OP_NOT_B = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned SWEEP_LEN = 32;

  // Truth table per op, bit position = {a,b} (MSB is a=1,b=1).
  localparam logic [3:0] GOLDEN [0:7] = '{
    4'b0011,  // NOT_A
    4'b0101,  // NOT_B
    4'b1000,  // AND
    4'b1110,  // OR
    4'b0111,  // NAND
    4'b0001,  // NOR
    4'b0110,  // XOR
    4'b1001   // XNOR
  };

  // Expected result bit for sweep vector {op,a,b}.
  function automatic logic golden_bit(input logic [4:0] idx);
    logic [3:0] row;
    row = GOLDEN[idx[4:2]];
    return row[idx[1:0]];
  endfunction

endpackage

// File: rtl/nand_func_bank.sv
// Combinational function generator: every function is formed from 2-input NANDs only.
module nand_func_bank
  import nand_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] n_ab, not_a, not_b, f_and, f_or, f_nor, t_a, t_b, f_xor, f_xnor;

  // NAND network, one gate level per line; XOR is the classic 4-NAND form.
  always_comb begin
    n_ab   = ~(a & b);
    not_a  = ~(a & a);
    not_b  = ~(b & b);
    f_and  = ~(n_ab & n_ab);
    f_or   = ~(not_a & not_b);
    f_nor  = ~(f_or & f_or);
    t_a    = ~(a & n_ab);
    t_b    = ~(b & n_ab);
    f_xor  = ~(t_a & t_b);
    f_xnor = ~(f_xor & f_xor);
  end

  // Function select.
  always_comb begin
    r = '0;
    case (op_e'(op))
      OP_NOT_A: r = not_a;
      OP_NOT_B: r = not_b;
      OP_AND:   r = f_and;
      OP_OR:    r = f_or;
      OP_NAND:  r = n_ab;
      OP_NOR:   r = f_nor;
      OP_XOR:   r = f_xor;
      OP_XNOR:  r = f_xnor;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/nand_logic_unit.sv
// Registered NAND logic unit with valid/ready stream and built-in truth-table sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | accepting stream transfers, waiting for sweep_start
// ST_SWEEP | applying vector idx to the function bank, one per cycle
// ST_DONE  | single-cycle sweep_done pulse, then back to idle
module nand_logic_unit
  import nand_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             sweep_start,
  input  logic             fault_inject,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             sweep_err,
  output logic [4:0]       err_idx
);

  state_e           state, state_nxt;
  logic [4:0]       idx;
  logic             in_sweep, xfer, start_acc, mismatch;
  logic [2:0]       fb_op;
  logic [WIDTH-1:0] fb_a, fb_b, fb_r, chk_r;

  assign in_sweep   = (state == ST_SWEEP);
  // rst_n gating keeps the unit from advertising readiness while held in reset.
  assign in_ready   = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
  assign xfer       = in_valid && in_ready;
  assign start_acc  = (state == ST_IDLE) && sweep_start && !out_valid && !xfer;
  assign sweep_busy = in_sweep;
  assign sweep_done = (state == ST_DONE);

  // Input mux: the sweep borrows the same function bank as the stream path.
  always_comb begin
    fb_op = op;
    fb_a  = a;
    fb_b  = b;
    if (in_sweep) begin
      fb_op = idx[4:2];
      fb_a  = {WIDTH{idx[1]}};
      fb_b  = {WIDTH{idx[0]}};
    end
  end

  nand_func_bank #(.WIDTH(WIDTH)) u_func_bank (
    .op (fb_op),
    .a  (fb_a),
    .b  (fb_b),
    .r  (fb_r)
  );

  // Fault injection flips bit 0 only on the checked copy, never the stream result.
  always_comb begin
    chk_r    = fb_r ^ WIDTH'(fault_inject);
    mismatch = in_sweep && (chk_r != {WIDTH{golden_bit(idx)}});
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_acc) state_nxt = ST_SWEEP;
      ST_SWEEP: if (idx == 5'(SWEEP_LEN - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Sweep index and sticky first-error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      sweep_err <= 1'b0;
      err_idx   <= '0;
    end else if (start_acc) begin
      idx       <= '0;
      sweep_err <= 1'b0;
      err_idx   <= '0;
    end else if (in_sweep) begin
      idx <= idx + 5'd1;
      if (mismatch && !sweep_err) begin
        sweep_err <= 1'b1;
        err_idx   <= idx;
      end
    end
  end

  // Output register: loads on transfer, drains when the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      y         <= fb_r;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_logic_unit.sv
// Directed self-checking bench for nand_logic_unit (WIDTH=8).
module tb_nand_logic_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, y;
  logic         sweep_start, fault_inject, sweep_busy, sweep_done, sweep_err;
  logic [4:0]   err_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nand_logic_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y            (y),
    .sweep_start  (sweep_start),
    .fault_inject (fault_inject),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .sweep_err    (sweep_err),
    .err_idx      (err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0: return ~x;
      3'd1: return ~z;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep from an accepted start; returns busy length and end flags.
  task automatic run_sweep(output int busy_len, output logic done_seen, output logic ov_seen);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    busy_len  = 0;
    ov_seen   = 1'b0;
    while (sweep_busy && busy_len < 40) begin
      if (out_valid || in_ready) ov_seen = 1'b1;
      tick();
      busy_len++;
    end
    done_seen = sweep_done;
  endtask

  initial begin
    int          blen;
    logic        dseen, oseen, any_done;
    logic [2:0]  o_prev;
    logic [W-1:0] a_prev, b_prev;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    sweep_start = 1'b0; fault_inject = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); op = 3'($urandom);
      a = W'($urandom); b = W'($urandom); sweep_start = 1'($urandom);
      fault_inject = 1'($urandom);
      tick();
      chk("rst_outs", {in_ready, out_valid, sweep_busy, sweep_done, sweep_err}, 32'h0);
      chk("rst_y_eidx", {y, err_idx}, 32'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b0; fault_inject = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", in_ready, 1);

    // Directed stream vectors.
    in_valid = 1'b1; op = 3'd6; a = 8'hF0; b = 8'h3C;
    tick();
    chk("xor_y", y, 8'hCC);
    chk("xor_ov", out_valid, 1);
    op = 3'd5;
    tick();
    chk("nor_y", y, 8'h03);

    // Back-to-back: all ops on random operands, one per cycle.
    for (int i = 0; i < 8; i++) begin
      op = 3'(i); a = W'($urandom); b = W'($urandom);
      o_prev = op; a_prev = a; b_prev = b;
      chk("b2b_rdy", in_ready, 1);
      tick();
      chk($sformatf("b2b_op%0d", i), y, ref_f(o_prev, a_prev, b_prev));
      chk("b2b_ov", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_ov", out_valid, 0);

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 8'hAA; b = 8'h0F;
    tick();
    chk("bp_y", y, 8'h0A);
    op = 3'd3; a = 8'h55; b = 8'h0F; sweep_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", in_ready, 0);
      tick();
      chk("bp_hold", {out_valid, y}, {1'b1, 8'h0A});
      chk("bp_nosweep", sweep_busy, 0);
    end
    sweep_start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    tick();
    chk("bp_new_y", y, 8'h5F);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);

    // Clean sweep.
    run_sweep(blen, dseen, oseen);
    chk("sw_len", blen, 32);
    chk("sw_done", dseen, 1);
    chk("sw_err", sweep_err, 0);
    chk("sw_stream_quiet", oseen, 0);
    chk("sw_ov", out_valid, 0);
    tick();
    chk("sw_done_1cyc", sweep_done, 0);

    // Faulted sweep.
    fault_inject = 1'b1;
    run_sweep(blen, dseen, oseen);
    chk("fl_len", blen, 32);
    chk("fl_done", dseen, 1);
    chk("fl_err", sweep_err, 1);
    chk("fl_idx", err_idx, 5'd0);
    fault_inject = 1'b0;
    tick();
    chk("fl_err_sticky", sweep_err, 1);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("fl_err_clr", {sweep_busy, sweep_err}, 32'h2);

    // Abort mid-sweep with reset.
    for (int i = 0; i < 40 && sweep_busy; i++) tick();
    tick();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (9) tick();
    chk("ab_busy_pre", sweep_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", {sweep_busy, sweep_done}, 32'h0);
    tick();
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sweep_done || sweep_busy) any_done = 1'b1;
      tick();
    end
    chk("ab_no_done", any_done, 0);

    // Collision: transfer wins over sweep_start.
    in_valid = 1'b1; sweep_start = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h0F;
    tick();
    in_valid = 1'b0; sweep_start = 1'b0;
    chk("col_y", {out_valid, y}, {1'b1, 8'hF0});
    chk("col_busy", sweep_busy, 0);
    repeat (3) tick();
    chk("col_busy_late", sweep_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
